// File: rtl/regfile_write_arbiter_if.sv
// Writeback bus: two valid/ready requesters, registered write port, read-bypass taps, stall count.
// Latency: n/a (signal bundle only).
// Backpressure: reqN_ready is driven by the arbiter (slave) side.
interface regfile_write_arbiter_if #(
    parameter int XLEN  = 32,
    parameter int AW    = 5,
    parameter int CNT_W = 16
);
    logic             req0_valid;
    logic             req0_ready;
    logic [AW-1:0]    req0_addr;
    logic [XLEN-1:0]  req0_data;
    logic             req1_valid;
    logic             req1_ready;
    logic [AW-1:0]    req1_addr;
    logic [XLEN-1:0]  req1_data;
    logic             we;
    logic [AW-1:0]    wa;
    logic [XLEN-1:0]  wd;
    logic [AW-1:0]    a1;
    logic [AW-1:0]    a2;
    logic [XLEN-1:0]  rf_rd1;
    logic [XLEN-1:0]  rf_rd2;
    logic [XLEN-1:0]  rd1;
    logic [XLEN-1:0]  rd2;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output req0_valid, req0_addr, req0_data,
        output req1_valid, req1_addr, req1_data,
        output a1, a2, rf_rd1, rf_rd2,
        input  req0_ready, req1_ready, we, wa, wd, rd1, rd2, stall_cnt
    );

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        input  req1_valid, req1_addr, req1_data,
        input  a1, a2, rf_rd1, rf_rd2,
        output req0_ready, req1_ready, we, wa, wd, rd1, rd2, stall_cnt
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin share of the regfile write port between ALU (req0) and load (req1) writeback.
// Latency: grant in cycle N -> we/wa/wd in N+1; optional read bypass (REGFILE_ARB_BYPASS_EN) is combinational.
// Backpressure: one grant per cycle, loser waits at most one cycle; ready held low during reset.
module regfile_write_arbiter #(
    parameter int XLEN  = 32,
    parameter int AW    = 5,
    parameter int CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    regfile_write_arbiter_if.slave  bus
);

    logic             gnt0;
    logic             gnt1;
    logic             last;
    logic             stall;
    logic [AW-1:0]    gnt_addr;
    logic [XLEN-1:0]  gnt_data;
    logic             we_q;
    logic [AW-1:0]    wa_q;
    logic [XLEN-1:0]  wd_q;
    logic [CNT_W-1:0] stall_q;

    // On contention the requester that did not win last time goes first.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (reset) begin
            if (bus.req0_valid && bus.req1_valid) begin
                gnt0 = last;
                gnt1 = ~last;
            end else begin
                gnt0 = bus.req0_valid;
                gnt1 = bus.req1_valid;
            end
        end
    end

    assign gnt_addr = gnt1 ? bus.req1_addr : bus.req0_addr;
    assign gnt_data = gnt1 ? bus.req1_data : bus.req0_data;
    assign stall    = (bus.req0_valid && !gnt0) || (bus.req1_valid && !gnt1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            we_q    <= 1'b0;
            wa_q    <= '0;
            wd_q    <= '0;
            last    <= 1'b1;
            stall_q <= '0;
        end else begin
            // x0 grants finish the handshake but never reach the register file.
            we_q <= (gnt0 || gnt1) && (gnt_addr != '0);
            if ((gnt0 || gnt1) && (gnt_addr != '0)) begin
                wa_q <= gnt_addr;
                wd_q <= gnt_data;
            end
            if (gnt0) begin
                last <= 1'b0;
            end else if (gnt1) begin
                last <= 1'b1;
            end
            if (stall && (stall_q != {CNT_W{1'b1}})) begin
                stall_q <= stall_q + 1'b1;
            end
        end
    end

    assign bus.req0_ready = gnt0;
    assign bus.req1_ready = gnt1;
    assign bus.we         = we_q;
    assign bus.wa         = wa_q;
    assign bus.wd         = wd_q;
    assign bus.stall_cnt  = stall_q;

`ifdef REGFILE_ARB_BYPASS_EN
    assign bus.rd1 = (we_q && (wa_q == bus.a1) && (bus.a1 != '0)) ? wd_q : bus.rf_rd1;
    assign bus.rd2 = (we_q && (wa_q == bus.a2) && (bus.a2 != '0)) ? wd_q : bus.rf_rd2;
`else
    assign bus.rd1 = bus.rf_rd1;
    assign bus.rd2 = bus.rf_rd2;
`endif

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the single register-file write port between two writeback requesters: requester 0 is the ALU/execute path and requester 1 is the load/memory path. Each requester uses a valid/ready handshake. A round-robin arbiter grants one request per cycle and registers the result into the register file's write signals (`we`, `wa`, `wd`). The block also counts contention stalls and, optionally, forwards the in-flight write to the register-file read ports.

## Interface
Parameters:
- `XLEN`, default 32: data width.
- `AW`, default 5: register address width.
- `CNT_W`, default 16: stall-counter width.

Ports:
- `clk` input 1: clock; all state updates on its rising edge.
- `reset` input 1: synchronous, active-low reset.
- `req0_valid` input 1: requester 0 has a write pending.
- `req0_ready` output 1: requester 0 is granted this cycle.
- `req0_addr` input AW: destination register, requester 0.
- `req0_data` input XLEN: write data, requester 0.
- `req1_valid`, `req1_ready`, `req1_addr`, `req1_data`: same as above, for requester 1.
- `we` output 1: register-file write enable (registered).
- `wa` output AW: register-file write address (registered).
- `wd` output XLEN: register-file write data (registered).
- `a1`, `a2` input AW: register-file read addresses (used for bypass only).
- `rf_rd1`, `rf_rd2` input XLEN: raw register-file read data.
- `rd1`, `rd2` output XLEN: read data delivered to the core.
- `stall_cnt` output CNT_W: saturating count of cycles in which a valid request was not granted.

## Operation
- **Transfer rule.** A transfer occurs on requester N when `reqN_valid && reqN_ready`. A requester holds `addr`/`data` stable while valid and not ready.
- **Arbitration.**
  - `reqN_ready` is combinational from the current valids and the `last` state bit.
  - At most one ready is high per cycle.
  - Only req0 valid: grant 0. Only req1 valid: grant 1.
  - Both valid: grant the requester other than `last`.
  - `last` updates to the granted index on every grant, including x0 grants.
  - No valid: no grant, and `last` holds.
- **Worst-case wait.** Round-robin bounds any wait to 1 cycle.
- **Write stage.** On a grant, the next cycle has `we`=1, `wa`=granted addr, `wd`=granted data. With no grant, `we`=0 and `wa`/`wd` hold their previous values.
- **x0 writes.** A grant with addr==0 completes the handshake (ready=1, `last` updates), but `we` stays 0 the next cycle.
- **Stall counter.** `stall_cnt` increments by 1 in each cycle where (`req0_valid && !req0_ready`) or (`req1_valid && !req1_ready`). It saturates at all-ones; there is no wrap.
- **Read path.** `rd1`/`rd2` equal `rf_rd1`/`rf_rd2` unless bypass is compiled in (see Configuration).

## Timing
- **Reset values** (applied at the clock edge where `reset`==0):
  - `we`=0, `wa`=0, `wd`=0, `stall_cnt`=0.
  - `last`=1, so requester 0 wins the first contention.
- **During reset.** `req0_ready`=`req1_ready`=0 while `reset`==0.
- **Reset mid-operation.** A granted write that has not yet appeared on `we` is dropped. Requesters retain their valid and re-arbitrate after reset.
- **Latency.** Grant in cycle N produces `we`/`wa`/`wd` in cycle N+1. The register file commits at the end of N+1.
- **Throughput.** One write per cycle sustained. With both requesters continuously valid, grants alternate 0,1,0,1…
- **Simultaneous requests to the same addr.** They are serialized in round-robin order; the later grant's data is the final value.
- **Valid dropped while waiting.** Permitted; no transfer and no error.

## Configuration
- Macro `REGFILE_ARB_BYPASS_EN`.
- **Defined:**
  - `rd1` = `wd` when `we` && `wa`==`a1` && `a1`!=0; otherwise `rd1` = `rf_rd1`.
  - `rd2` follows the same rule with `a2`/`rf_rd2`.
  - The forwarding mux is purely combinational, with no added latency.
- **Undefined:** `rd1`=`rf_rd1` and `rd2`=`rf_rd2` (wires). `a1`/`a2` are unused.

## Test plan
- **Reset.** Hold `reset`=0 for 2 cycles with both valid → both ready=0, `we`=0, `stall_cnt`=0. Release → first cycle grants req0.
- **Single requester.** req0 writes (addr 5, 0x5) then (addr 7, 0x7) on back-to-back cycles → `we`=1 with `wa`=5/`wd`=0x5, then `wa`=7/`wd`=0x7, each 1 cycle after its grant. `stall_cnt` stays 0.
- **Contention.** Both valid for 4 cycles; req0 carries (addr 3, 0xA0..) and req1 carries (addr 4, 0xB0..).
  - Grants go 0,1,0,1.
  - `stall_cnt`=4.
  - No request waits more than 1 cycle.
- **x0 discard.** req1 writes (addr 0, 0xDEADBEEF) → `req1_ready`=1, `we`=0 the next cycle, `last`=1 (a following contention grants req0).
- **Bypass (macro defined).** Grant (addr 9, 0x1234) with `a1`=9, `a2`=0, `rf_rd1`=0 → in the `we` cycle `rd1`=0x1234 and `rd2`=`rf_rd2`. With the macro undefined, `rd1`=0.
- **Reset mid-write and saturation.**
  - Assert `reset`=0 in the grant cycle → no `we` pulse follows.
  - Separately, force 2^CNT_W+3 stall cycles → `stall_cnt` holds at all-ones.
